// File: rtl/bf_stream_sequencer.sv
// Streams two polynomials from polynomial RAM through the 4-lane butterfly (ADDSUB or pointwise MULT)
// and writes the results back. MULT mode is only built when BF_SEQ_MULT_EN is defined.
module bf_stream_sequencer #(
   parameter int N_WORDS         = 32,
   parameter int WB_DELAY_ADDSUB = 4,
   parameter int WB_DELAY_MULT   = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op_mode,
   input  logic        op_sub,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_rd_en,
   output logic        mem_rd_sel,
   output logic [4:0]  mem_rd_addr,
   input  logic [95:0] mem_rd_data,
   output logic        coef_rd_en,
   output logic [4:0]  coef_rd_addr,
   output logic [1:0]  bf_mode,
   output logic [2:0]  bf_stage,
   output logic        bf_type,
   output logic        bf_pre_load,
   output logic        bf_load,
   output logic [95:0] bf_in_data,
   input  logic [95:0] bf_out_data,
   output logic        mem_wr_en,
   output logic [4:0]  mem_wr_addr,
   output logic [95:0] mem_wr_data
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [1:0] MODE_ADDSUB = 2'd3;
   localparam logic [7:0] J_LAST_A    = 8'(2 * N_WORDS - 1);
   localparam logic [5:0] WR_LAST     = 6'(N_WORDS - 1);

`ifdef BF_SEQ_MULT_EN
   localparam bit         MULT_EN   = 1'b1;
   localparam logic [1:0] MODE_MULT = 2'd2;
   localparam logic [7:0] J_LAST_M  = 8'(4 * N_WORDS - 1);
`else
   localparam bit         MULT_EN   = 1'b0;
`endif

   // One shared token line; each mode taps it at its own pipeline depth.
   localparam int DL_LEN = (MULT_EN && (WB_DELAY_MULT > WB_DELAY_ADDSUB)) ?
                           WB_DELAY_MULT : WB_DELAY_ADDSUB;

   state_t      state_reg;
   logic [7:0]  j_reg;
   logic [2:0]  drain_cnt_reg;
   logic [5:0]  wr_cnt_reg;
   logic        busy_reg, done_reg, err_reg;
   logic        rd_en_reg, rd_sel_reg;
   logic [4:0]  rd_addr_reg;
   logic [1:0]  mode_reg;
   logic [2:0]  stage_reg;
   logic        type_reg, pre_load_reg, load_reg;
   logic [DL_LEN-1:0] dl_reg;

   logic [7:0]  j_next;
   logic [7:0]  j_last;
   logic [2:0]  drain_len;
   logic [2:0]  stage_of_j;
   logic        is_mult;
   logic        mode_legal;
   logic        dl_tap;

   assign j_next = j_reg + 8'd1;

`ifdef BF_SEQ_MULT_EN
   assign is_mult    = (mode_reg == MODE_MULT);
   assign mode_legal = (op_mode == MODE_ADDSUB) || (op_mode == MODE_MULT);
   assign j_last     = is_mult ? J_LAST_M : J_LAST_A;
   assign drain_len  = is_mult ? 3'd4 : 3'd2;
   assign dl_tap     = is_mult ? dl_reg[WB_DELAY_MULT-1] : dl_reg[WB_DELAY_ADDSUB-1];
`else
   assign is_mult    = 1'b0;
   assign mode_legal = (op_mode == MODE_ADDSUB);
   assign j_last     = J_LAST_A;
   assign drain_len  = 3'd2;
   assign dl_tap     = dl_reg[WB_DELAY_ADDSUB-1];
`endif

   assign stage_of_j = is_mult ? {1'b0, j_reg[1:0]} : {2'b00, j_reg[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         j_reg         <= '0;
         drain_cnt_reg <= '0;
         wr_cnt_reg    <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         rd_en_reg     <= 1'b0;
         rd_sel_reg    <= 1'b0;
         rd_addr_reg   <= '0;
         mode_reg      <= '0;
         stage_reg     <= '0;
         type_reg      <= 1'b0;
         pre_load_reg  <= 1'b0;
         load_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if (mode_legal) begin
                     state_reg     <= S_RUN;
                     busy_reg      <= 1'b1;
                     mode_reg      <= op_mode;
                     type_reg      <= op_sub & (op_mode == MODE_ADDSUB);
                     j_reg         <= '0;
                     drain_cnt_reg <= '0;
                     wr_cnt_reg    <= '0;
                     rd_en_reg     <= 1'b1;
                     rd_sel_reg    <= 1'b0;
                     rd_addr_reg   <= '0;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               // Outputs describe the data cycle of the read issued this cycle.
               pre_load_reg <= rd_en_reg & ~rd_sel_reg;
               load_reg     <= rd_en_reg & rd_sel_reg;
               stage_reg    <= stage_of_j;
               j_reg        <= j_next;
               if (j_reg == j_last) begin
                  rd_en_reg     <= 1'b0;
                  rd_sel_reg    <= 1'b0;
                  rd_addr_reg   <= '0;
                  drain_cnt_reg <= '0;
                  state_reg     <= S_DRAIN;
               end else begin
                  rd_en_reg   <= ~is_mult | ~j_next[1];
                  rd_sel_reg  <= j_next[0];
                  rd_addr_reg <= is_mult ? j_next[6:2] : j_next[5:1];
               end
            end
            S_DRAIN: begin
               pre_load_reg <= 1'b0;
               load_reg     <= 1'b0;
               if (drain_cnt_reg != drain_len) begin
                  stage_reg     <= stage_of_j;
                  j_reg         <= j_next;
                  drain_cnt_reg <= drain_cnt_reg + 3'd1;
               end else begin
                  stage_reg <= '0;
               end
            end
            S_DONE: begin
               state_reg    <= S_IDLE;
               busy_reg     <= 1'b0;
               mode_reg     <= '0;
               type_reg     <= 1'b0;
               stage_reg    <= '0;
               pre_load_reg <= 1'b0;
               load_reg     <= 1'b0;
            end
            default: state_reg <= S_IDLE;
         endcase

         if (dl_tap) begin
            wr_cnt_reg <= wr_cnt_reg + 6'd1;
            if (wr_cnt_reg == WR_LAST) begin
               state_reg <= S_DONE;
               done_reg  <= 1'b1;
            end
         end
      end
   end

   // A token enters on every B-load cycle and marks the cycle its result appears.
   generate
      if (DL_LEN > 1) begin : g_dl_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst) dl_reg <= '0;
            else     dl_reg <= {dl_reg[DL_LEN-2:0], load_reg};
         end
      end else begin : g_dl_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) dl_reg <= '0;
            else     dl_reg <= load_reg;
         end
      end
   endgenerate

`ifdef BF_SEQ_MULT_EN
   logic       coef_en_reg;
   logic [4:0] coef_addr_reg;

   // Zeta pair k is fetched while word k's B operand is read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_en_reg   <= 1'b0;
         coef_addr_reg <= '0;
      end else if (state_reg == S_RUN && j_reg != j_last && is_mult && j_next[1:0] == 2'b01) begin
         coef_en_reg   <= 1'b1;
         coef_addr_reg <= j_next[6:2];
      end else begin
         coef_en_reg   <= 1'b0;
         coef_addr_reg <= '0;
      end
   end

   assign coef_rd_en   = coef_en_reg;
   assign coef_rd_addr = coef_addr_reg;
`else
   assign coef_rd_en   = 1'b0;
   assign coef_rd_addr = '0;
`endif

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign err         = err_reg;
   assign mem_rd_en   = rd_en_reg;
   assign mem_rd_sel  = rd_sel_reg;
   assign mem_rd_addr = rd_addr_reg;
   assign bf_mode     = mode_reg;
   assign bf_stage    = stage_reg;
   assign bf_type     = type_reg;
   assign bf_pre_load = pre_load_reg;
   assign bf_load     = load_reg;
   assign bf_in_data  = mem_rd_data;
   assign mem_wr_en   = dl_tap;
   assign mem_wr_addr = wr_cnt_reg[4:0];
   assign mem_wr_data = bf_out_data;

endmodule

// File: tb/tb_bf_stream_sequencer.sv
// Scoreboard bench for bf_stream_sequencer: RAM and butterfly stubs, timeline reference model,
// write-back queue checked by an independent monitor. MULT runs only when BF_SEQ_MULT_EN is defined.
module tb_bf_stream_sequencer;
   localparam int N    = 32;
   localparam int WB_A = 4;
   localparam int WB_M = 18;
`ifdef BF_SEQ_MULT_EN
   localparam bit MB = 1'b1;
`else
   localparam bit MB = 1'b0;
`endif

   logic        clk, rst, start, op_sub;
   logic [1:0]  op_mode;
   logic        busy, done, err;
   logic        mem_rd_en, mem_rd_sel;
   logic [4:0]  mem_rd_addr;
   logic [95:0] mem_rd_data;
   logic        coef_rd_en;
   logic [4:0]  coef_rd_addr;
   logic [1:0]  bf_mode;
   logic [2:0]  bf_stage;
   logic        bf_type, bf_pre_load, bf_load;
   logic [95:0] bf_in_data, bf_out_data;
   logic        mem_wr_en;
   logic [4:0]  mem_wr_addr;
   logic [95:0] mem_wr_data;

   bf_stream_sequencer #(.N_WORDS(N), .WB_DELAY_ADDSUB(WB_A), .WB_DELAY_MULT(WB_M)) dut (
      .clk(clk), .rst(rst), .start(start), .op_mode(op_mode), .op_sub(op_sub),
      .busy(busy), .done(done), .err(err),
      .mem_rd_en(mem_rd_en), .mem_rd_sel(mem_rd_sel), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr),
      .bf_mode(bf_mode), .bf_stage(bf_stage), .bf_type(bf_type), .bf_pre_load(bf_pre_load),
      .bf_load(bf_load), .bf_in_data(bf_in_data), .bf_out_data(bf_out_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   typedef struct {int cyc; logic [4:0] addr; logic [95:0] data;} wr_t;
   typedef struct {int due; logic [95:0] data;} bq_t;

   wr_t         wq[$];
   bq_t         bq[$];
   logic [95:0] mem_a [N];
   logic [95:0] mem_b [N];
   logic [95:0] a_lat;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          tl_base = 0;
   bit          tl_active = 1'b0;
   int          exp_err_cyc = -10;
   logic [1:0]  cur_mode = 2'd3;
   logic        cur_sub = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [95:0] bf_fn(logic [95:0] a, logic [95:0] b, logic [1:0] m, logic s);
      if (m == 2'd2) return a ^ {b[47:0], b[95:48]};
      return s ? (a - b) : (a + b);
   endfunction

   function automatic int done_off_of(logic [1:0] m);
      int step = (m == 2'd2) ? 4 : 2;
      int wb   = (m == 2'd2) ? WB_M : WB_A;
      return 3 + step * (N - 1) + wb + 1;
   endfunction

   task automatic chk(string name, logic [95:0] got, logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // Cycle counter and butterfly stub output: result appears exactly WB cycles after its B-load.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bq.size() > 0 && bq[0].due == cyc) begin
         bf_out_data = bq[0].data;
         void'(bq.pop_front());
      end else begin
         bf_out_data = {$urandom, $urandom, $urandom};
      end
   end

   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= mem_rd_sel ? mem_b[mem_rd_addr] : mem_a[mem_rd_addr];

   always @(negedge clk) begin
      if (bf_pre_load) a_lat = mem_rd_data;
      if (bf_load)
         bq.push_back('{cyc + ((bf_mode == 2'd2) ? WB_M : WB_A),
                        bf_fn(a_lat, bf_in_data, bf_mode, bf_type)});
   end

   // Monitor: write-back scoreboard plus per-cycle timeline model of the control outputs.
   always @(negedge clk) begin : mon
      int off, q, d, c, step, nrd;
      bit m, rd_exp, coef_exp;
      wr_t e;
      if (mem_wr_en) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", 1'b1, 1'b0);
         end else begin
            e = wq.pop_front();
            chk("wr_cycle", 96'(cyc), 96'(e.cyc));
            chk("wr_addr", mem_wr_addr, e.addr);
            chk("wr_data", mem_wr_data, e.data);
         end
      end
      off = cyc - tl_base;
      if (tl_active && off >= 1 && off <= done_off_of(cur_mode)) begin
         m    = (cur_mode == 2'd2);
         step = m ? 4 : 2;
         nrd  = m ? 4 * N : 2 * N;
         q    = off - 1;
         d    = off - 2;
         rd_exp = 1'b0;
         if (q < nrd) begin
            c = q % step;
            rd_exp = m ? (c < 2) : 1'b1;
            chk("rd_en", mem_rd_en, rd_exp);
            if (rd_exp) begin
               chk("rd_sel", mem_rd_sel, 96'(c));
               chk("rd_addr", mem_rd_addr, 96'(q / step));
            end
         end else begin
            chk("rd_en_after", mem_rd_en, 1'b0);
         end
         if (d >= 0 && d < nrd) begin
            c = d % step;
            chk("pre_load", bf_pre_load, c == 0);
            chk("load", bf_load, c == 1);
            chk("stage", bf_stage, 96'(c));
            if (!m) chk("bf_type", bf_type, cur_sub);
         end else begin
            chk("pre_load_off", bf_pre_load, 1'b0);
            chk("load_off", bf_load, 1'b0);
         end
`ifdef BF_SEQ_MULT_EN
         coef_exp = m && d >= 0 && (d % 4) == 0 && (d / 4) < N;
         chk("coef_en", coef_rd_en, coef_exp);
         if (coef_exp) chk("coef_addr", coef_rd_addr, 96'(d / 4));
`else
         coef_exp = 1'b0;
         chk("coef_en_tied", coef_rd_en, coef_exp);
`endif
         chk("busy", busy, 1'b1);
         chk("done", done, off == done_off_of(cur_mode));
         chk("bf_mode", bf_mode, cur_mode);
         chk("err_busy", err, 1'b0);
      end else begin
         chk("idle_busy", busy, 1'b0);
         chk("idle_done", done, 1'b0);
         chk("idle_rd_en", mem_rd_en, 1'b0);
         chk("idle_load", {bf_pre_load, bf_load}, 2'b00);
         chk("idle_mode", bf_mode, 2'b00);
         chk("idle_coef", coef_rd_en, 1'b0);
         chk("idle_err", err, cyc == exp_err_cyc);
      end
   end

   task automatic start_op(input logic [1:0] mode, input logic sub, input bit directed);
      bit legal;
      int step, wb;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         mem_a[k] = directed ? 96'(k) : {$urandom, $urandom, $urandom};
         mem_b[k] = directed ? 96'd1 : {$urandom, $urandom, $urandom};
      end
      legal = (mode == 2'd3) || (MB && mode == 2'd2);
      if (legal) begin
         cur_mode  = mode;
         cur_sub   = sub & (mode == 2'd3);
         tl_base   = cyc;
         tl_active = 1'b1;
         step = (mode == 2'd2) ? 4 : 2;
         wb   = (mode == 2'd2) ? WB_M : WB_A;
         for (int k = 0; k < N; k++)
            wq.push_back('{cyc + 3 + step * k + wb, 5'(k), bf_fn(mem_a[k], mem_b[k], mode, cur_sub)});
      end else begin
         exp_err_cyc = cyc + 1;
      end
      $display("op t0=%0d mode=%0d sub=%0d legal=%0d", cyc, mode, sub, legal);
      start   = 1'b1;
      op_mode = mode;
      op_sub  = sub;
      @(negedge clk);
      start   = 1'b0;
      op_mode = 2'($urandom);
      op_sub  = 1'($urandom);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", seen, 1'b1);
      chk("wq_empty", 96'(wq.size()), 96'd0);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_ctl"}, {busy, done, err, mem_rd_en, mem_rd_sel, coef_rd_en, bf_type,
                          bf_pre_load, bf_load, mem_wr_en}, '0);
      chk({tag, "_addr"}, {mem_rd_addr, coef_rd_addr, mem_wr_addr}, '0);
      chk({tag, "_mode_stage"}, {bf_mode, bf_stage}, '0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_mode = 2'd0; op_sub = 1'b0;
      bf_out_data = '0; mem_rd_data = '0; a_lat = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      start_op(2'd3, 1'b0, 1'b1);
      wait_done();

      // Subtract run with a stray start during RUN that must be ignored.
      start_op(2'd3, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      start = 1'b1; op_mode = 2'($urandom_range(0, 3)); op_sub = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
      wait_done();

      start_op(2'd1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      start_op(2'd0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);

      start_op(2'd2, 1'b0, 1'b0);
`ifdef BF_SEQ_MULT_EN
      wait_done();
`else
      repeat (4) @(negedge clk);
`endif

      // Abort an ADDSUB run at t0+20; no further writes may appear.
      start_op(2'd3, 1'b0, 1'b0);
      for (int i = 0; i < 100 && cyc != tl_base + 20; i++) @(negedge clk);
      #2;
      rst = 1'b1;
      tl_active = 1'b0;
      wq.delete();
      bq.delete();
      #1;
      check_all_zero("abort");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_op(2'd3, 1'b0, 1'b0);
      wait_done();

      // Back-to-back random operations, each started the cycle after done.
      for (int r = 0; r < 3; r++) begin
         start_op((MB && $urandom_range(0, 1) == 1) ? 2'd2 : 2'd3, 1'($urandom), 1'b0);
         wait_done();
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
